seq_serializer: RTL and testbench
=================================

// Module: seq_serializer
// PURPOSE
//  - Upstream feed stage for the serial sequence detector: takes parallel words over a valid/ready
//    handshake and emits them MSB-first, one bit per clk, onto the detector's seq_in line.
//  - One-entry holding buffer lets back-to-back words stream with no idle bit between them.
//  - seq_valid qualifies each bit; idle level is driven when no word is in flight.
// PARAMETERS
//  - WIDTH       8    bits per parallel word (2..32)
//  - IDLE_LEVEL  1'b0 value driven on seq_out while idle (chosen so the detector sees no false 1s)
// PORTS
//  - clk         in   1      rising-edge clock
//  - rst         in   1      asynchronous, active-high reset
//  - data_in     in   WIDTH  parallel word; sampled when load_valid && load_ready
//  - load_valid  in   1      producer has a word on data_in
//  - load_ready  out  1      block can accept a word this cycle
//  - seq_out     out  1      serial bit; connects to detector seq_in
//  - seq_valid   out  1      seq_out carries a data (or parity) bit this cycle
//  - busy        out  1      shifter or holding buffer occupied
// BEHAVIOUR
//  - Reset (async assert, sync release): seq_out=IDLE_LEVEL, seq_valid=0, busy=0, load_ready=1;
//    shifter, bit counter, holding buffer cleared. Reset mid-word discards all data.
//  - load_ready = !hold_full (registered state, not combinational on load_valid).
//  - FSM states: IDLE, SHIFT (+PARITY with macro).
//  - IDLE: accept at edge N moves word straight into the shifter (holding buffer bypassed);
//    after edge N seq_out=data_in[WIDTH-1], seq_valid=1, state=SHIFT, bit count=WIDTH-1.
//  - SHIFT: each edge shifts left by one; bit k (MSB first) is held exactly one cycle.
//    Word of WIDTH bits occupies WIDTH consecutive cycles.
//  - Accept during SHIFT writes to the holding buffer (hold_full=1, load_ready=0 next cycle).
//  - End of word (last bit cycle), priority order:
//      hold_full        -> hold word loaded into shifter, hold_full=0, next bit its MSB (no gap);
//      else accept now  -> new word loaded directly into shifter (no gap);
//      else             -> IDLE, seq_out=IDLE_LEVEL, seq_valid=0.
//  - Simultaneous accept and hold-drain at the same edge cannot occur (load_ready=0 while full).
//  - busy = (state!=IDLE) | hold_full. Throughput: one word per WIDTH cycles sustained.
//  - load_valid while load_ready=0 is ignored; producer must hold data_in stable until accepted.
// CONFIGURATION
//  - SEQ_SER_PARITY_EN defined: after the LSB of each word, one extra cycle in PARITY state drives
//    even parity (XOR of the word) with seq_valid=1; end-of-word rules then apply after PARITY.
//    Word occupies WIDTH+1 cycles.
//  - Undefined: no PARITY state; word occupies exactly WIDTH cycles.
// STRUCTURE
//  - Package seq_pkg: state encoding (ST_IDLE, ST_SHIFT, ST_PARITY) and constant for
//    counter width $clog2(WIDTH+1); shared with the detector bench.
//  - Sub-module seq_ser_holdbuf: one-entry register + full flag (write, read, full, data).
//  - Top: FSM, shift register, bit counter, optional parity accumulator.
// TESTING (WIDTH=8)
//  - Reset: rst=1 for 50 ns mid-word -> seq_out=0, seq_valid=0, load_ready=1 immediately.
//  - Single word 8'hB4 accepted at edge N -> seq_out 1,0,1,1,0,1,0,0 on cycles N..N+7, then idle.
//  - Back-to-back 8'hFF then 8'h01 (second offered during shift) -> 16 contiguous valid bits,
//    load_ready low from second accept until first word's last bit.
//  - Third word offered while hold full -> load_ready=0, word not taken until drain edge.
//  - Feed 8'b0000_0110 into detector -> detector pattern seen, det_out asserts as its spec requires.
//  - SEQ_SER_PARITY_EN: 8'h07 -> 8 data bits then parity 1; 8'h03 -> parity 0; 9 cycles per word.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the serial sequence path: FSM state encoding and
// bit-counter sizing helper used by the serializer and the detector bench.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } seq_state_e;

  localparam int SEQ_WIDTH = 8;

  function automatic int seq_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int SEQ_CNT_W = seq_cnt_w(SEQ_WIDTH);

endpackage

// File: rtl/seq_ser_holdbuf.sv
// One-entry holding buffer with full flag; lets the next word wait
// while the shifter is still emitting the current one.
module seq_ser_holdbuf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_wr) begin
      r_full <= 1'b1;
      r_data <= i_wdata;
    end else if (i_rd) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feed for the sequence detector, MSB first.
// Define SEQ_SER_PARITY_EN to append an even-parity bit to every word.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy
);

  localparam int            CW       = seq_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  seq_state_e       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_seq_out;
  logic             r_seq_valid;

  logic             w_full;
  logic [WIDTH-1:0] w_hold_data;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_eow;
  logic             w_load;
  logic             w_hold_wr;
  logic             w_hold_rd;
  logic             w_stop;
  logic             w_shift;

`ifdef SEQ_SER_PARITY_EN
  logic             r_par;
  logic             w_to_par;

  assign w_eow    = (r_state == ST_PARITY);
  assign w_to_par = (r_state == ST_SHIFT) & (r_cnt == '0);
`else
  assign w_eow    = (r_state == ST_SHIFT) & (r_cnt == '0);
`endif

  assign w_accept  = load_valid & ~w_full;
  assign w_hold_rd = w_eow & w_full;
  // Buffered word has priority; a fresh word bypasses the buffer only
  // when the shifter is free at this edge.
  assign w_load    = w_hold_rd |
                     (w_accept & ((r_state == ST_IDLE) | w_eow));
  assign w_hold_wr = w_accept & ~w_load;
  assign w_word    = w_full ? w_hold_data : data_in;
  assign w_stop    = w_eow & ~w_load;
  assign w_shift   = (r_state == ST_SHIFT) & (r_cnt != '0);

  seq_ser_holdbuf #(
    .WIDTH (WIDTH)
  ) u_holdbuf (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_hold_wr),
    .i_wdata (data_in),
    .i_rd    (w_hold_rd),
    .o_full  (w_full),
    .o_data  (w_hold_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_seq_out   <= IDLE_LEVEL;
      r_seq_valid <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        w_load: begin
          r_state     <= ST_SHIFT;
          r_shift     <= w_word;
          r_cnt       <= LAST_IDX;
          r_seq_out   <= w_word[WIDTH-1];
          r_seq_valid <= 1'b1;
`ifdef SEQ_SER_PARITY_EN
          r_par       <= ^w_word;
`endif
        end
`ifdef SEQ_SER_PARITY_EN
        w_to_par: begin
          r_state   <= ST_PARITY;
          r_seq_out <= r_par;
        end
`endif
        w_stop: begin
          r_state     <= ST_IDLE;
          r_seq_out   <= IDLE_LEVEL;
          r_seq_valid <= 1'b0;
        end
        w_shift: begin
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_seq_out <= r_shift[WIDTH-2];
          r_cnt     <= r_cnt - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign load_ready = ~w_full;
  assign seq_out    = r_seq_out;
  assign seq_valid  = r_seq_valid;
  assign busy       = (r_state != ST_IDLE) | w_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized bench for seq_serializer against a word-queue reference model.
// Build with SEQ_SER_PARITY_EN defined to cover the parity variant.
module tb_seq_serializer;

`ifdef SEQ_SER_PARITY_EN
  localparam int WLEN = 9;
`else
  localparam int WLEN = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready;
  logic       seq_out;
  logic       seq_valid;
  logic       busy;

  int n_checks;
  int n_errors;

  logic [7:0] wq[$];
  int         pos;
  logic       cap[$];
  int         run_len;
  int         max_run;

  seq_serializer #(
    .WIDTH      (8),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .seq_out    (seq_out),
    .seq_valid  (seq_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic m_valid();
    return wq.size() > 0;
  endfunction

  function automatic logic m_out();
    logic [7:0] w;
    if (wq.size() == 0) return 1'b0;
    w = wq[0];
    if (pos < 8) return w[7-pos];
    return ^w;
  endfunction

  // Drive one cycle, advance the model at the edge, compare after it.
  task automatic step(input logic lv, input logic [7:0] d,
                      output logic acc);
    load_valid = lv;
    data_in    = d;
    acc        = lv && (wq.size() < 2);
    @(posedge clk);
    if (wq.size() > 0) begin
      pos++;
      if (pos == WLEN) begin
        void'(wq.pop_front());
        pos = 0;
      end
    end
    if (acc) wq.push_back(d);
    @(negedge clk);
    check("seq_valid", 32'(seq_valid), 32'(m_valid()));
    check("seq_out", 32'(seq_out), 32'(m_out()));
    check("load_ready", 32'(load_ready), 32'(wq.size() < 2));
    check("busy", 32'(busy), 32'(wq.size() > 0));
    if (seq_valid) begin
      cap.push_back(seq_out);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  endtask

  task automatic idle_cycles(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, a);
  endtask

  task automatic clear_cap();
    cap.delete();
    run_len = 0;
    max_run = 0;
  endtask

  function automatic logic [31:0] cap_word(input int start);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[30:0], cap[start+i]};
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seq_out"}, 32'(seq_out), 32'd0);
    check({tag, "_seq_valid"}, 32'(seq_valid), 32'd0);
    check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic       a;
    logic       lv;
    logic [7:0] d;
    int         waits;
    n_checks   = 0;
    n_errors   = 0;
    pos        = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    data_in    = 8'h00;
    clear_cap();

    #23;
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    // Single word MSB first, then idle
    clear_cap();
    step(1'b1, 8'hB4, a);
    check("b4_accept", 32'(a), 32'd1);
    idle_cycles(WLEN + 3);
    check("b4_nbits", 32'(cap.size()), 32'(WLEN));
    check("b4_bits", cap_word(0), 32'hB4);
`ifdef SEQ_SER_PARITY_EN
    check("b4_par", 32'(cap[8]), 32'd0);
`endif

    // Back-to-back: second offered while first shifts
    clear_cap();
    step(1'b1, 8'hFF, a);
    step(1'b1, 8'h01, a);
    check("b2b_second_acc", 32'(a), 32'd1);
    check("b2b_ready_low", 32'(load_ready), 32'd0);
    idle_cycles(2 * WLEN + 3);
    check("b2b_contig", 32'(max_run), 32'(2 * WLEN));
    check("b2b_w0", cap_word(0), 32'hFF);
    check("b2b_w1", cap_word(WLEN), 32'h01);

    // Third word waits for the hold buffer to drain
    clear_cap();
    step(1'b1, 8'hAA, a);
    step(1'b1, 8'h55, a);
    waits = 0;
    a = 1'b0;
    while (!a && waits < 40) begin
      step(1'b1, 8'hC3, a);
      if (!a) waits++;
    end
    check("third_wait", 32'(waits), 32'(WLEN - 1));
    idle_cycles(3 * WLEN + 3);
    check("third_contig", 32'(max_run), 32'(3 * WLEN));
    check("third_w2", cap_word(2 * WLEN), 32'hC3);

`ifdef SEQ_SER_PARITY_EN
    clear_cap();
    step(1'b1, 8'h07, a);
    idle_cycles(WLEN + 2);
    check("par_07", 32'(cap[8]), 32'd1);
    clear_cap();
    step(1'b1, 8'h03, a);
    idle_cycles(WLEN + 2);
    check("par_03", 32'(cap[8]), 32'd0);
`endif

    // Reset mid-word discards everything at once
    step(1'b1, 8'h9C, a);
    step(1'b1, 8'h3E, a);
    idle_cycles(2);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    #49;
    check_reset_outputs("held");
    rst = 1'b0;
    wq.delete();
    pos = 0;
    @(negedge clk);
    idle_cycles(2);

    // Random traffic; producer holds data until it is taken
    lv = 1'b0;
    d  = 8'h00;
    a  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (a || !lv) begin
        lv = ($urandom_range(0, 9) < 6);
        d  = 8'($urandom);
      end
      step(lv, d, a);
      if (!lv) a = 1'b0;
    end
    idle_cycles(3 * WLEN);
    check("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
